// File: rtl/sr_pulse_seq.sv
// Set/reset pulse sequencer: delayed, repeated train of one-window S and R pulses for an SR latch.
// First S lands d enabled windows after accept; no backpressure, i_CEN_n=1 freezes all state and outputs.
module sr_pulse_seq #(
    parameter int CW = 8,
    parameter int RW = 4
) (
    input  logic          i_CLK,
    input  logic          i_RST_n,
    input  logic          i_CEN_n,
    input  logic          i_START,
    input  logic          i_ABORT,
    input  logic [CW-1:0] i_DELAY,
    input  logic [CW-1:0] i_WIDTH,
    input  logic [CW-1:0] i_GAP,
    input  logic [RW-1:0] i_REPEAT,
    output logic          o_S,
    output logic          o_R,
    output logic          o_Q,
    output logic          o_BUSY,
    output logic          o_DONE
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_SET,
        ST_HOLD,
        ST_RST,
        ST_GAP
    } state_t;

    localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
    localparam logic [RW-1:0] C_REP_ONE = RW'(1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_width;
    logic [CW-1:0] r_gap;
    logic [RW-1:0] r_rep;
    logic          r_abrt;
    logic          r_S;
    logic          r_R;
    logic          r_Q;
    logic          r_BUSY;
    logic          r_DONE;

    logic          w_cnt_zero;
    logic [CW-1:0] w_cnt_dec;
    logic          w_stop;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_cnt_dec  = r_cnt - C_CNT_ONE;
    // A forced R window (abort while set) must end the sequence without DONE.
    assign w_stop     = i_ABORT || r_abrt;

    always_ff @(posedge i_CLK) begin
        if (!i_RST_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_width <= '0;
            r_gap   <= '0;
            r_rep   <= '0;
            r_abrt  <= 1'b0;
            r_S     <= 1'b0;
            r_R     <= 1'b0;
            r_Q     <= 1'b0;
            r_BUSY  <= 1'b0;
            r_DONE  <= 1'b0;
        end else if (!i_CEN_n) begin
            r_S    <= 1'b0;
            r_R    <= 1'b0;
            r_DONE <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_START && !i_ABORT) begin
                        r_width <= i_WIDTH;
                        r_gap   <= i_GAP;
                        r_rep   <= i_REPEAT;
                        r_abrt  <= 1'b0;
                        r_BUSY  <= 1'b1;
                        if (i_DELAY == '0) begin
                            r_state <= ST_SET;
                            r_S     <= 1'b1;
                            r_Q     <= 1'b1;
                        end else begin
                            r_state <= ST_DELAY;
                            r_cnt   <= i_DELAY - C_CNT_ONE;
                        end
                    end
                end
                ST_DELAY, ST_GAP: begin
                    if (i_ABORT) begin
                        r_state <= ST_IDLE;
                        r_BUSY  <= 1'b0;
                    end else if (w_cnt_zero) begin
                        r_state <= ST_SET;
                        r_S     <= 1'b1;
                        r_Q     <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                ST_SET: begin
                    if (i_ABORT || r_width == '0) begin
                        r_state <= ST_RST;
                        r_R     <= 1'b1;
                        r_Q     <= 1'b0;
                        r_abrt  <= i_ABORT;
                    end else begin
                        r_state <= ST_HOLD;
                        r_cnt   <= r_width - C_CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (i_ABORT || w_cnt_zero) begin
                        r_state <= ST_RST;
                        r_R     <= 1'b1;
                        r_Q     <= 1'b0;
                        r_abrt  <= i_ABORT;
                    end else begin
                        r_cnt <= w_cnt_dec;
                    end
                end
                ST_RST: begin
                    if (w_stop || r_rep == '0) begin
                        r_state <= ST_IDLE;
                        r_BUSY  <= 1'b0;
                        r_DONE  <= !w_stop;
                        r_abrt  <= 1'b0;
                    end else begin
                        r_rep <= r_rep - C_REP_ONE;
                        if (r_gap == '0) begin
                            r_state <= ST_SET;
                            r_S     <= 1'b1;
                            r_Q     <= 1'b1;
                        end else begin
                            r_state <= ST_GAP;
                            r_cnt   <= r_gap - C_CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_BUSY  <= 1'b0;
                    r_Q     <= 1'b0;
                end
            endcase
        end
    end

    assign o_S    = r_S;
    assign o_R    = r_R;
    assign o_Q    = r_Q;
    assign o_BUSY = r_BUSY;
    assign o_DONE = r_DONE;

endmodule

// File: doc/sr_pulse_seq.md
# sr_pulse_seq

Programmable set/reset pulse sequencer: the driving side of the SR-latch primitives used throughout the 005297 model. On a start command it emits a delayed, repeated train of one-window set and reset pulses. The S/R pair is guaranteed never to be asserted together. It feeds any SR latch directly and is used wherever the original silicon gates a latch from a timing chain, such as bubble function-pulse windows and gate enables. `o_Q` mirrors the state the driven latch must hold, so benches can compare against the latch output directly.

## Interface
- `CW`, default 8: width of the delay, width and gap counters.
- `RW`, default 4: width of the repeat count.

- `i_CLK`, in, 1: master clock; all state changes on its rising edge.
- `i_RST_n`, in, 1: synchronous active-low reset, sampled on `i_CLK`; it overrides `i_CEN_n`.
- `i_CEN_n`, in, 1: active-low clock enable; state advances only on enabled edges.
- `i_START`, in, 1: start request, sampled on enabled edges.
- `i_ABORT`, in, 1: abort request, sampled on enabled edges.
- `i_DELAY`, in, CW: enabled windows between accept and the first S pulse.
- `i_WIDTH`, in, CW: windows between the S pulse and the R pulse, exclusive of both.
- `i_GAP`, in, CW: windows between an R pulse and the next S pulse.
- `i_REPEAT`, in, RW: number of extra pulses; the total is REPEAT+1.
- `o_S`, out, 1: set pulse to the latch.
- `o_R`, out, 1: reset pulse to the latch.
- `o_Q`, out, 1: expected latch state.
- `o_BUSY`, out, 1: sequence in progress.
- `o_DONE`, out, 1: one-window pulse on normal completion.

## Operation
- **Definitions.**
  - Window n is the interval after enabled edge E_n.
  - E_0 is the accept edge.
  - All outputs are registered.
  - Outputs hold while `i_CEN_n`=1.
- **Reset.** State goes to IDLE and all outputs go to 0: `o_S`, `o_R`, `o_Q`, `o_BUSY` and `o_DONE`.
- **States:** IDLE, DELAY, SET, HOLD, RST, GAP.
- **Accept.**
  - Condition: in IDLE with `i_START`=1 and `i_ABORT`=0.
  - Latches `i_DELAY`, `i_WIDTH`, `i_GAP` and `i_REPEAT`; later input changes are ignored until the next accept.
  - `o_BUSY`=1 from window 0.
  - `i_START` is ignored while busy.
- **Pulse timing (d = delay, w = width, g = gap).**
  - First S in window d, so d=0 puts S in window 0.
  - R in window d+w+1.
  - Pulse k (k = 0..REPEAT) has S at d+k·(w+g+2) and R at d+w+1+k·(w+g+2).
  - w=0 and g=0 are legal.
- **`o_S` and `o_R` are single-window pulses.**
  - `o_S` and `o_R` are never 1 in the same window.
- **`o_Q`.**
  - `o_Q`=1 from each S window through the window before its R, which is w+1 windows.
  - `o_Q`=0 in the R window, matching SR latch behaviour where set and reset act combinationally.
- **Completion.**
  - The window after the final R has `o_DONE`=1 and `o_BUSY`=0, and state returns to IDLE.
  - A new START may be accepted on the edge that begins the DONE window's successor, i.e. while IDLE.
- **Repeat counter.** Decrements at each R and terminates after 0.
- **Abort.**
  - In DELAY or GAP: IDLE in the next window; no R is issued and no DONE.
  - In SET or HOLD (`o_Q`=1): the next window is a forced R window (`o_R`=1, `o_Q`=0), then IDLE; no DONE.
  - In RST: proceeds to IDLE with no DONE, even if this was the final pulse.
  - In IDLE: no effect. START together with ABORT is not accepted.
- **Reset mid-sequence.** All outputs clear with no R pulse issued; the downstream latch is reset by its own reset.

## Timing
- Latency from accept to the first S is d windows (d enabled edges).
- Period is w+g+2 windows.
- Total busy length is d + (REPEAT+1)·(w+2) + REPEAT·g windows.
- Abort latency is 1 window.
- Every output changes only on an enabled edge or on a reset edge.
- Counters are CW bits with no wrap: a maximum value of 2^CW−1 is counted exactly.

## Test plan
- **Repeated train.** d=2, w=3, g=1, REPEAT=1, `i_CEN_n`=0 throughout.
  - S in windows 2 and 8; R in windows 6 and 12.
  - `o_Q` high in windows 2–5 and 8–11.
  - `o_DONE` in window 13.
  - `o_BUSY` high in windows 0–12.
- **Minimum sequence.** d=0, w=0, g=0, REPEAT=2.
  - S in windows 0, 2 and 4; R in windows 1, 3 and 5; DONE in window 6.
  - S and R are never high together.
- **Clock enable stall.** Repeat the first scenario with `i_CEN_n`=1 on every other clock.
  - Identical sequence measured in enabled edges.
  - Outputs are frozen on disabled clocks.
- **Abort while set.** Assert abort with the latch set (window 4 of the first scenario).
  - R in window 5, IDLE from window 6, no DONE.
- **Abort in GAP and START while busy.**
  - Abort in GAP: IDLE next window with no R; a START pulsed while busy is ignored.
  - START together with ABORT in IDLE: `o_BUSY` stays 0.
- **Reset mid-sequence.**
  - Assert `i_RST_n`=0 in window 3 with `i_CEN_n`=1: all outputs are 0 after that edge.
  - After release, a fresh START produces the first-scenario pattern exactly.
